// File: rtl/axi_resp_slice.sv
// Register slice for the AXI B and R response channels. Each channel is an
// independent two-entry skid buffer, or a plain wire-through when its slice parameter is 0.
module axi_resp_slice #(
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned B_USER_WIDTH = 1,
    parameter int unsigned R_USER_WIDTH = 1,
    parameter int unsigned B_SLICE      = 1,
    parameter int unsigned R_SLICE      = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ID_WIDTH-1:0]     in_b_id,
    input  logic [1:0]              in_b_resp,
    input  logic [B_USER_WIDTH-1:0] in_b_user,
    input  logic                    in_b_valid,
    output logic                    in_b_ready,

    output logic [ID_WIDTH-1:0]     out_b_id,
    output logic [1:0]              out_b_resp,
    output logic [B_USER_WIDTH-1:0] out_b_user,
    output logic                    out_b_valid,
    input  logic                    out_b_ready,

    input  logic [ID_WIDTH-1:0]     in_r_id,
    input  logic [DATA_WIDTH-1:0]   in_r_data,
    input  logic [1:0]              in_r_resp,
    input  logic                    in_r_last,
    input  logic [R_USER_WIDTH-1:0] in_r_user,
    input  logic                    in_r_valid,
    output logic                    in_r_ready,

    output logic [ID_WIDTH-1:0]     out_r_id,
    output logic [DATA_WIDTH-1:0]   out_r_data,
    output logic [1:0]              out_r_resp,
    output logic                    out_r_last,
    output logic [R_USER_WIDTH-1:0] out_r_user,
    output logic                    out_r_valid,
    input  logic                    out_r_ready
);

    localparam int unsigned BW = ID_WIDTH + 2 + B_USER_WIDTH;
    localparam int unsigned RW = ID_WIDTH + DATA_WIDTH + 3 + R_USER_WIDTH;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [BW-1:0] w_b_in;
    logic [BW-1:0] w_b_out;
    logic [RW-1:0] w_r_in;
    logic [RW-1:0] w_r_out;

    assign w_b_in = {in_b_id, in_b_resp, in_b_user};
    assign {out_b_id, out_b_resp, out_b_user} = w_b_out;

    assign w_r_in = {in_r_id, in_r_data, in_r_resp, in_r_last, in_r_user};
    assign {out_r_id, out_r_data, out_r_resp, out_r_last, out_r_user} = w_r_out;

    // ---------------------------------------------------------------- B channel
    if (B_SLICE != 0) begin : g_b_reg
        logic [1:0]    r_state;
        logic [1:0]    w_state_d;
        logic [BW-1:0] r_m;
        logic [BW-1:0] r_s;
        logic [BW-1:0] w_m_d;
        logic [BW-1:0] w_s_d;
        logic          r_valid;
        logic          r_ready;
        logic          w_in_hs;
        logic          w_out_hs;

        assign w_in_hs  = in_b_valid & r_ready;
        assign w_out_hs = r_valid & out_b_ready;

        always_comb begin
            w_state_d = r_state;
            w_m_d     = r_m;
            w_s_d     = r_s;
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_hs) begin
                        w_m_d     = w_b_in;
                        w_state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_hs && w_out_hs) begin
                        w_m_d = w_b_in;
                    end else if (w_in_hs) begin
                        w_s_d     = w_b_in;
                        w_state_d = ST_FULL;
                    end else if (w_out_hs) begin
                        w_state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_hs) begin
                        w_m_d     = r_s;
                        w_state_d = ST_BUSY;
                    end
                end
                default: w_state_d = ST_EMPTY;
            endcase
        end

        // valid/ready are decoded from the next state so both leave the block from flops
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_EMPTY;
                r_m     <= '0;
                r_s     <= '0;
                r_valid <= 1'b0;
                r_ready <= 1'b1;
            end else begin
                r_state <= w_state_d;
                r_m     <= w_m_d;
                r_s     <= w_s_d;
                r_valid <= (w_state_d != ST_EMPTY);
                r_ready <= (w_state_d != ST_FULL);
            end
        end

        assign w_b_out     = r_m;
        assign out_b_valid = r_valid;
        assign in_b_ready  = r_ready;
    end else begin : g_b_byp
        assign w_b_out     = w_b_in;
        assign out_b_valid = in_b_valid;
        assign in_b_ready  = out_b_ready;
    end

    // ---------------------------------------------------------------- R channel
    if (R_SLICE != 0) begin : g_r_reg
        logic [1:0]    r_state;
        logic [1:0]    w_state_d;
        logic [RW-1:0] r_m;
        logic [RW-1:0] r_s;
        logic [RW-1:0] w_m_d;
        logic [RW-1:0] w_s_d;
        logic          r_valid;
        logic          r_ready;
        logic          w_in_hs;
        logic          w_out_hs;

        assign w_in_hs  = in_r_valid & r_ready;
        assign w_out_hs = r_valid & out_r_ready;

        always_comb begin
            w_state_d = r_state;
            w_m_d     = r_m;
            w_s_d     = r_s;
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_hs) begin
                        w_m_d     = w_r_in;
                        w_state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_hs && w_out_hs) begin
                        w_m_d = w_r_in;
                    end else if (w_in_hs) begin
                        w_s_d     = w_r_in;
                        w_state_d = ST_FULL;
                    end else if (w_out_hs) begin
                        w_state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_hs) begin
                        w_m_d     = r_s;
                        w_state_d = ST_BUSY;
                    end
                end
                default: w_state_d = ST_EMPTY;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_EMPTY;
                r_m     <= '0;
                r_s     <= '0;
                r_valid <= 1'b0;
                r_ready <= 1'b1;
            end else begin
                r_state <= w_state_d;
                r_m     <= w_m_d;
                r_s     <= w_s_d;
                r_valid <= (w_state_d != ST_EMPTY);
                r_ready <= (w_state_d != ST_FULL);
            end
        end

        assign w_r_out     = r_m;
        assign out_r_valid = r_valid;
        assign in_r_ready  = r_ready;
    end else begin : g_r_byp
        assign w_r_out     = w_r_in;
        assign out_r_valid = in_r_valid;
        assign in_r_ready  = out_r_ready;
    end

endmodule

// File: tb/tb_axi_resp_slice.sv
// Scoreboard bench for axi_resp_slice: accepted beats are queued per channel and a
// monitor compares every presented output beat and the valid/ready levels against the queue.
module tb_axi_resp_slice;

    localparam int BW = 4 + 2 + 1;
    localparam int RW = 4 + 64 + 2 + 1 + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  in_b_id;
    logic [1:0]  in_b_resp;
    logic [0:0]  in_b_user;
    logic        in_b_valid;
    logic        in_b_ready;
    logic [3:0]  out_b_id;
    logic [1:0]  out_b_resp;
    logic [0:0]  out_b_user;
    logic        out_b_valid;
    logic        out_b_ready;
    logic [3:0]  in_r_id;
    logic [63:0] in_r_data;
    logic [1:0]  in_r_resp;
    logic        in_r_last;
    logic [0:0]  in_r_user;
    logic        in_r_valid;
    logic        in_r_ready;
    logic [3:0]  out_r_id;
    logic [63:0] out_r_data;
    logic [1:0]  out_r_resp;
    logic        out_r_last;
    logic [0:0]  out_r_user;
    logic        out_r_valid;
    logic        out_r_ready;

    // B-bypass build shares the stimulus
    logic        byp_in_b_ready;
    logic [3:0]  byp_out_b_id;
    logic [1:0]  byp_out_b_resp;
    logic [0:0]  byp_out_b_user;
    logic        byp_out_b_valid;
    logic        byp_in_r_ready;
    logic [3:0]  byp_out_r_id;
    logic [63:0] byp_out_r_data;
    logic [1:0]  byp_out_r_resp;
    logic        byp_out_r_last;
    logic [0:0]  byp_out_r_user;
    logic        byp_out_r_valid;

    axi_resp_slice dut (
        .clk(clk), .rst(rst),
        .in_b_id(in_b_id), .in_b_resp(in_b_resp), .in_b_user(in_b_user),
        .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
        .out_b_id(out_b_id), .out_b_resp(out_b_resp), .out_b_user(out_b_user),
        .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
        .in_r_id(in_r_id), .in_r_data(in_r_data), .in_r_resp(in_r_resp),
        .in_r_last(in_r_last), .in_r_user(in_r_user),
        .in_r_valid(in_r_valid), .in_r_ready(in_r_ready),
        .out_r_id(out_r_id), .out_r_data(out_r_data), .out_r_resp(out_r_resp),
        .out_r_last(out_r_last), .out_r_user(out_r_user),
        .out_r_valid(out_r_valid), .out_r_ready(out_r_ready)
    );

    axi_resp_slice #(.B_SLICE(0), .R_SLICE(1)) dut_byp (
        .clk(clk), .rst(rst),
        .in_b_id(in_b_id), .in_b_resp(in_b_resp), .in_b_user(in_b_user),
        .in_b_valid(in_b_valid), .in_b_ready(byp_in_b_ready),
        .out_b_id(byp_out_b_id), .out_b_resp(byp_out_b_resp), .out_b_user(byp_out_b_user),
        .out_b_valid(byp_out_b_valid), .out_b_ready(out_b_ready),
        .in_r_id(in_r_id), .in_r_data(in_r_data), .in_r_resp(in_r_resp),
        .in_r_last(in_r_last), .in_r_user(in_r_user),
        .in_r_valid(in_r_valid), .in_r_ready(byp_in_r_ready),
        .out_r_id(byp_out_r_id), .out_r_data(byp_out_r_data), .out_r_resp(byp_out_r_resp),
        .out_r_last(byp_out_r_last), .out_r_user(byp_out_r_user),
        .out_r_valid(byp_out_r_valid), .out_r_ready(out_r_ready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int r_cnt = 0;
    int r_first = 0;
    int r_lastc = 0;

    logic [BW-1:0] q_b[$];
    logic [RW-1:0] q_r[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Stimulus side: record every accepted beat as the expected output
    always @(negedge clk) begin
        if (!rst) begin
            if (in_b_valid && in_b_ready) q_b.push_back({in_b_id, in_b_resp, in_b_user});
            if (in_r_valid && in_r_ready)
                q_r.push_back({in_r_id, in_r_data, in_r_resp, in_r_last, in_r_user});
        end
    end

    // Monitor: occupancy before this cycle's input handshake fixes valid/ready
    always @(negedge clk) begin
        int occ;
        #2;
        if (!rst) begin
            occ = q_b.size() - int'(in_b_valid && in_b_ready);
            check("b_in_ready", in_b_ready, occ < 2);
            check("b_out_valid", out_b_valid, occ > 0);
            if (out_b_valid && q_b.size() > 0) begin
                check("b_payload", {out_b_id, out_b_resp, out_b_user}, q_b[0]);
                if (out_b_ready) void'(q_b.pop_front());
            end
            occ = q_r.size() - int'(in_r_valid && in_r_ready);
            check("r_in_ready", in_r_ready, occ < 2);
            check("r_out_valid", out_r_valid, occ > 0);
            if (out_r_valid && q_r.size() > 0) begin
                check("r_payload", {out_r_id, out_r_data, out_r_resp, out_r_last, out_r_user},
                      q_r[0]);
                if (out_r_ready) begin
                    void'(q_r.pop_front());
                    if (r_cnt == 0) r_first = cyc;
                    r_lastc = cyc;
                    r_cnt++;
                end
            end
        end
    end

    task automatic b_beat(input logic [3:0] id, input logic [1:0] resp, input logic u);
        bit hs;
        int n;
        in_b_valid = 1'b1;
        in_b_id    = id;
        in_b_resp  = resp;
        in_b_user  = u;
        n = 0;
        do begin
            @(negedge clk);
            hs = in_b_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 50);
        if (!hs) check("b_accept_timeout", 0, 1);
        in_b_valid = 1'b0;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [63:0] data, input logic last);
        bit hs;
        int n;
        in_r_valid = 1'b1;
        in_r_id    = id;
        in_r_data  = data;
        in_r_resp  = id[1:0];
        in_r_last  = last;
        in_r_user  = id[0];
        n = 0;
        do begin
            @(negedge clk);
            hs = in_r_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 50);
        if (!hs) check("r_accept_timeout", 0, 1);
        in_r_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_b.size() != 0 || q_r.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_b_empty", q_b.size(), 0);
        check("drain_r_empty", q_r.size(), 0);
    endtask

    initial begin
        in_b_id = '0; in_b_resp = '0; in_b_user = '0; in_b_valid = 1'b0;
        in_r_id = '0; in_r_data = '0; in_r_resp = '0; in_r_last = 1'b0; in_r_user = '0;
        in_r_valid = 1'b0;
        out_b_ready = 1'b1;
        out_r_ready = 1'b1;

        #1 rst = 1'b1;
        #1;
        check("rst_b_valid", out_b_valid, 0);
        check("rst_b_ready", in_b_ready, 1);
        check("rst_b_payload", {out_b_id, out_b_resp, out_b_user}, 0);
        check("rst_r_valid", out_r_valid, 0);
        check("rst_r_ready", in_r_ready, 1);
        check("rst_r_payload", {out_r_id, out_r_data, out_r_resp, out_r_last, out_r_user}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Bypassed B follows inputs combinationally; its R stays registered
        in_b_id = 4'h5; in_b_resp = 2'b01; in_b_user = 1'b1; out_b_ready = 1'b0;
        #1;
        check("byp_b_payload", {byp_out_b_id, byp_out_b_resp, byp_out_b_user}, 7'b0101_01_1);
        check("byp_b_ready_lo", byp_in_b_ready, 0);
        out_b_ready = 1'b1;
        in_b_valid = 1'b1;
        in_r_valid = 1'b1;
        #1;
        check("byp_b_ready_hi", byp_in_b_ready, 1);
        check("byp_b_valid", byp_out_b_valid, 1);
        check("byp_r_not_comb", byp_out_r_valid, 0);
        in_b_valid = 1'b0;
        in_r_valid = 1'b0;
        @(posedge clk);
        #1;

        // Single B beat
        b_beat(4'hA, 2'b10, 1'b0);
        check("b1_valid", out_b_valid, 1);
        check("b1_payload", {out_b_id, out_b_resp, out_b_user}, 7'b1010_10_0);
        check("b1_in_ready", in_b_ready, 1);
        @(posedge clk);
        #1;
        check("b1_valid_gone", out_b_valid, 0);

        // 16-beat R burst, back to back
        r_cnt = 0;
        for (int i = 0; i < 16; i++) r_beat(4'h3, 64'(i), i == 15);
        drain();
        check("burst_beats", r_cnt, 16);
        check("burst_consecutive", r_lastc - r_first, 15);

        // Stall: second beat lands in the skid register
        out_r_ready = 1'b0;
        r_beat(4'h6, 64'hAA0, 1'b0);
        r_beat(4'h6, 64'hAA1, 1'b0);
        check("stall_in_ready", in_r_ready, 0);
        check("stall_data", out_r_data, 64'hAA0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("stall_hold", out_r_data, 64'hAA0);
        end
        out_r_ready = 1'b1;
        r_beat(4'h6, 64'hAA2, 1'b0);
        r_beat(4'h6, 64'hAA3, 1'b1);
        drain();

        // Concurrent random traffic on both channels
        fork
            begin
                bit hs;
                for (int i = 0; i < 5000; i++) begin
                    @(negedge clk);
                    hs = in_b_valid && in_b_ready;
                    @(posedge clk);
                    #1;
                    if (hs || !in_b_valid) begin
                        in_b_valid = 1'($urandom_range(0, 1));
                        in_b_id    = 4'($urandom);
                        in_b_resp  = 2'($urandom);
                        in_b_user  = 1'($urandom);
                    end
                    out_b_ready = 1'($urandom_range(0, 1));
                end
                in_b_valid = 1'b0;
                out_b_ready = 1'b1;
            end
            begin
                bit hs;
                for (int i = 0; i < 5000; i++) begin
                    @(negedge clk);
                    hs = in_r_valid && in_r_ready;
                    @(posedge clk);
                    #1;
                    if (hs || !in_r_valid) begin
                        in_r_valid = 1'($urandom_range(0, 1));
                        in_r_id    = 4'($urandom);
                        in_r_data  = {$urandom, $urandom};
                        in_r_resp  = 2'($urandom);
                        in_r_last  = 1'($urandom);
                        in_r_user  = 1'($urandom);
                    end
                    out_r_ready = ($urandom_range(0, 3) != 0);
                end
                in_r_valid = 1'b0;
                out_r_ready = 1'b1;
            end
        join
        drain();

        // Reset while both channels are FULL
        out_b_ready = 1'b0;
        out_r_ready = 1'b0;
        b_beat(4'h1, 2'b01, 1'b1);
        b_beat(4'h2, 2'b11, 1'b1);
        r_beat(4'h9, 64'hDEAD_BEEF, 1'b1);
        r_beat(4'h9, 64'hCAFE_F00D, 1'b1);
        check("full_b_ready", in_b_ready, 0);
        check("full_r_ready", in_r_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_b_valid", out_b_valid, 0);
        check("arst_b_ready", in_b_ready, 1);
        check("arst_b_payload", {out_b_id, out_b_resp, out_b_user}, 0);
        check("arst_r_valid", out_r_valid, 0);
        check("arst_r_ready", in_r_ready, 1);
        check("arst_r_payload", {out_r_id, out_r_data, out_r_resp, out_r_last, out_r_user}, 0);
        q_b.delete();
        q_r.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        out_b_ready = 1'b1;
        out_r_ready = 1'b1;
        @(posedge clk);
        #1;
        b_beat(4'h3, 2'b01, 1'b1);
        check("post_rst_b_valid", out_b_valid, 1);
        check("post_rst_b_id", out_b_id, 4'h3);
        r_beat(4'hC, 64'h1234, 1'b1);
        check("post_rst_r_data", out_r_data, 64'h1234);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
